// File: rtl/pwm_leg_sequencer.sv
// Start/stop/fault sequencer and period-aligned dead-time scheduler for a group of PWM legs.
// Latency: every output is registered and follows the deciding clock edge by one cycle.
// Backpressure: dt_write_ready drops while a dead-time commit waits for its apply point.
module pwm_leg_sequencer #(
  parameter int unsigned N_LEGS           = 3,
  parameter int unsigned BOOTSTRAP_CYCLES = 1000,
  parameter int unsigned MIN_DEADTIME     = 2,
  parameter int unsigned RESET_DEADTIME   = 100
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [N_LEGS-1:0] leg_mask,
  input  logic              sync_pulse,
  input  logic              fault_in,
  input  logic              fault_clear,
  input  logic              dt_write_valid,
  input  logic [15:0]       dt_write_data,
  output logic              dt_write_ready,
  output logic [15:0]       dead_time,
  output logic [N_LEGS-1:0] gate_enable,
  output logic [N_LEGS-1:0] bootstrap_on,
  output logic              gate_kill,
  output logic              running,
  output logic              dt_clamped
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_BOOTSTRAP = 3'd1,
    ST_ARM       = 3'd2,
    ST_RUN       = 3'd3,
    ST_STOPPING  = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  // The counter holds "cycles left minus one", so it never needs to hold BOOTSTRAP_CYCLES itself.
  localparam int unsigned CNT_W     = (BOOTSTRAP_CYCLES > 2) ? $clog2(BOOTSTRAP_CYCLES) : 1;
  localparam int unsigned BOOT_LOAD = (BOOTSTRAP_CYCLES > 0) ? (BOOTSTRAP_CYCLES - 1) : 0;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BOOT_LOAD);
  localparam logic [15:0]      MIN_DT   = 16'(MIN_DEADTIME);
  localparam logic [15:0]      RST_DT   = 16'(RESET_DEADTIME);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_LEGS-1:0]   mask_q, mask_d;

  logic [15:0]         shadow_q, shadow_d;
  logic                pend_q, pend_d;
  logic [15:0]         dead_time_q, dead_time_d;
  logic                clamped_q, clamped_d;

  logic [N_LEGS-1:0]   gate_enable_q, gate_enable_d;
  logic [N_LEGS-1:0]   bootstrap_on_q, bootstrap_on_d;
  logic                gate_kill_q, gate_kill_d;
  logic                running_q, running_d;

  logic                dt_accept;
  logic                dt_commit;
  logic                dt_below_min;

  // Next-state: fault overrides everything, then stop, then start.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    if (fault_in) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A start that coincides with stop is dropped.
          if (start && !stop) begin
            mask_d = leg_mask;
            cnt_d  = CNT_LOAD;
            if (BOOTSTRAP_CYCLES == 0) begin
              state_d = ST_ARM;
            end else begin
              state_d = ST_BOOTSTRAP;
            end
          end
        end
        ST_BOOTSTRAP: begin
          if (stop) begin
            state_d = ST_IDLE;
          end else if (cnt_q == '0) begin
            state_d = ST_ARM;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_ARM: begin
          if (stop) begin
            state_d = ST_IDLE;
          end else if (sync_pulse) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          // A sync on the stop cycle does not count: legs stop on the following boundary.
          if (stop) begin
            state_d = ST_STOPPING;
          end
        end
        ST_STOPPING: begin
          if (sync_pulse) begin
            state_d = ST_IDLE;
          end
        end
        ST_FAULT: begin
          if (fault_clear) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output decode from the next state so the registered outputs track the state with no extra lag.
  always_comb begin
    gate_enable_d  = '0;
    bootstrap_on_d = '0;
    gate_kill_d    = 1'b0;
    running_d      = 1'b0;
    case (state_d)
      ST_BOOTSTRAP: bootstrap_on_d = mask_d;
      ST_RUN: begin
        gate_enable_d = mask_d;
        running_d     = 1'b1;
      end
      ST_STOPPING:  gate_enable_d = mask_d;
      ST_FAULT:     gate_kill_d   = 1'b1;
      default: begin
        gate_enable_d  = '0;
        bootstrap_on_d = '0;
      end
    endcase
  end

  // Dead-time shadow: accept one write, hold it until the apply point, then publish it.
  always_comb begin
    shadow_d     = shadow_q;
    pend_d       = pend_q;
    dead_time_d  = dead_time_q;
    clamped_d    = clamped_q;
    dt_below_min = (dt_write_data < MIN_DT);
    dt_accept    = dt_write_valid && !pend_q;
    // Outside active switching there is no period to align to, so commit immediately.
    dt_commit    = pend_q && ((state_q == ST_IDLE) || (state_q == ST_FAULT) || sync_pulse);
    if (dt_commit) begin
      dead_time_d = shadow_q;
      pend_d      = 1'b0;
    end
    if (dt_accept) begin
      shadow_d = dt_below_min ? MIN_DT : dt_write_data;
      pend_d   = 1'b1;
      if (dt_below_min) begin
        clamped_d = 1'b1;
      end
    end
  end

  // State, counter and latched mask registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
    end
  end

  // Registered gate-side outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      gate_enable_q  <= '0;
      bootstrap_on_q <= '0;
      gate_kill_q    <= 1'b0;
      running_q      <= 1'b0;
    end else begin
      gate_enable_q  <= gate_enable_d;
      bootstrap_on_q <= bootstrap_on_d;
      gate_kill_q    <= gate_kill_d;
      running_q      <= running_d;
    end
  end

  // Dead-time registers; reset discards any pending commit.
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_q    <= RST_DT;
      pend_q      <= 1'b0;
      dead_time_q <= RST_DT;
      clamped_q   <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      pend_q      <= pend_d;
      dead_time_q <= dead_time_d;
      clamped_q   <= clamped_d;
    end
  end

  assign dt_write_ready = ~pend_q;
  assign dead_time      = dead_time_q;
  assign dt_clamped     = clamped_q;
  assign gate_enable    = gate_enable_q;
  assign bootstrap_on   = bootstrap_on_q;
  assign gate_kill      = gate_kill_q;
  assign running        = running_q;

endmodule
